// File: rtl/mips_lcd_drv.sv
// HD44780-style LCD bus sequencer: setup / enable pulse / hold / execute-wait timing.
// Optional write FIFO when LCD_FIFO_EN is defined; otherwise a single-byte engine.
module mips_lcd_drv #(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 4,
    parameter int T_EXEC  = 2000,
    parameter int T_CLR   = 80000
`ifdef LCD_FIFO_EN
    ,
    parameter int FIFO_AW = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       full_o,
    output logic       ovf_o,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

    localparam logic [16:0] L_SETUP = 17'(T_SETUP - 1);
    localparam logic [16:0] L_EN    = 17'(T_EN - 1);
    localparam logic [16:0] L_HOLD  = 17'(T_HOLD - 1);
    localparam logic [16:0] L_EXEC  = 17'(T_EXEC - 1);
    localparam logic [16:0] L_CLR   = 17'(T_CLR - 1);

    state_t      state, state_n;
    logic [16:0] cnt, cnt_n;
    logic        exec_end;
    logic        pend;
    logic        take;
    logic        accept;
    logic        is_clr;
    logic        en_n;
    logic [8:0]  src;

    assign exec_end = (state == EXEC) && (cnt == '0);
    assign is_clr   = !lcd_rs && (lcd_data inside {8'h01, 8'h02, 8'h03});
    assign lcd_rw   = 1'b0;

`ifdef LCD_FIFO_EN
    // The byte on the bus keeps its slot until its EXEC ends, so "full"
    // counts the transfer in flight as well as the queued ones.
    localparam int DEPTH = 1 << FIFO_AW;

    logic [8:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] rd_nxt;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               push;
    logic               pop;

    assign full   = (count == (FIFO_AW+1)'(DEPTH));
    assign pop    = exec_end;
    assign accept = wr_i && (!full || pop);
    assign push   = accept;
    assign rd_nxt = rd_ptr + FIFO_AW'(1);
    assign pend   = (count > (FIFO_AW+1)'(1)) || wr_i;
    assign src    = (count > (FIFO_AW+1)'(1)) ? mem[rd_nxt] : {rs_i, data_i};
    assign busy_o = (state != IDLE) || (count != '0);
    assign full_o = full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {rs_i, data_i};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_nxt;
            unique case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
`else
    // A write is only taken when idle or on the final EXEC cycle.
    assign accept = wr_i && ((state == IDLE) || exec_end);
    assign pend   = wr_i;
    assign src    = {rs_i, data_i};
    assign busy_o = (state != IDLE);
    assign full_o = busy_o;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend) begin
                    state_n = SETUP;
                    cnt_n   = L_SETUP;
                    take    = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = PULSE;
                    cnt_n   = L_EN;
                end else begin
                    cnt_n = cnt - 17'd1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = L_HOLD;
                end else begin
                    cnt_n = cnt - 17'd1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = EXEC;
                    cnt_n   = is_clr ? L_CLR : L_EXEC;
                end else begin
                    cnt_n = cnt - 17'd1;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    if (pend) begin
                        state_n = SETUP;
                        cnt_n   = L_SETUP;
                        take    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 17'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        en_n = (state_n == PULSE);
    end

    // lcd_en is registered so the strobe is glitch-free and drops on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lcd_en   <= 1'b0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            lcd_en <= en_n;
            if (take) begin
                lcd_rs   <= src[8];
                lcd_data <= src[7:0];
            end
            if (wr_i && !accept) ovf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_lcd_drv.sv
// Directed bench for mips_lcd_drv, default build (no FIFO).
// Timing params: T_SETUP=2 T_EN=3 T_HOLD=2 T_EXEC=5 T_CLR=20.
module tb_mips_lcd_drv;

    logic       clk;
    logic       rst;
    logic       wr_i;
    logic       rs_i;
    logic [7:0] data_i;
    logic       busy_o;
    logic       full_o;
    logic       ovf_o;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    int checks   = 0;
    int failures = 0;
    bit rw_mon   = 0;

    mips_lcd_drv #(
        .T_SETUP(2),
        .T_EN   (3),
        .T_HOLD (2),
        .T_EXEC (5),
        .T_CLR  (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (wr_i),
        .rs_i    (rs_i),
        .data_i  (data_i),
        .busy_o  (busy_o),
        .full_o  (full_o),
        .ovf_o   (ovf_o),
        .lcd_data(lcd_data),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_en  (lcd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rw_mon) begin
            checks++;
            assert (lcd_rw === 1'b0) else begin
                failures++;
                $error("FAIL lcd_rw observed=%b expected=0", lcd_rw);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One write from IDLE; cycle 1 is the cycle after the write is sampled.
    task automatic send(input logic rs, input logic [7:0] d,
                        output logic [7:0] d1, output logic rs1,
                        output int first_en, output int en_cnt,
                        output int done);
        rs_i     = rs;
        data_i   = d;
        wr_i     = 1'b1;
        d1       = 8'hxx;
        rs1      = 1'bx;
        first_en = -1;
        en_cnt   = 0;
        done     = -1;
        for (int c = 1; c <= 200 && done < 0; c++) begin
            tick();
            wr_i = 1'b0;
            if (c == 1) begin
                d1  = lcd_data;
                rs1 = lcd_rs;
            end
            if (lcd_en) begin
                if (first_en < 0) first_en = c;
                en_cnt++;
            end
            if (!busy_o) done = c;
        end
    endtask

    logic [7:0] d1;
    logic       rs1;
    int         fe;
    int         ec;
    int         dn;
    int         lowc;
    int         en2;

    initial begin
        rst    = 1'b0;
        wr_i   = 1'b0;
        rs_i   = 1'b0;
        data_i = 8'h00;
        tick();
        tick();
        rw_mon = 1;

        check("rst_data", 32'(lcd_data), 32'h00);
        check("rst_rs",   32'(lcd_rs),   32'h0);
        check("rst_en",   32'(lcd_en),   32'h0);
        check("rst_busy", 32'(busy_o),   32'h0);
        check("rst_full", 32'(full_o),   32'h0);
        check("rst_ovf",  32'(ovf_o),    32'h0);
        rst = 1'b1;
        tick();

        send(1'b1, 8'h41, d1, rs1, fe, ec, dn);
        check("data_latch", 32'(d1),  32'h41);
        check("data_rs",    32'(rs1), 32'h1);
        check("data_en_at", 32'(fe),  32'd3);
        check("data_en_n",  32'(ec),  32'd3);
        check("data_done",  32'(dn),  32'd13);
        check("data_full",  32'(full_o), 32'h0);

        send(1'b0, 8'h01, d1, rs1, fe, ec, dn);
        check("clr_rs",   32'(rs1), 32'h0);
        check("clr_en_n", 32'(ec),  32'd3);
        check("clr_done", 32'(dn),  32'd28);

        send(1'b0, 8'h38, d1, rs1, fe, ec, dn);
        check("cmd38_done", 32'(dn), 32'd13);

        send(1'b0, 8'h03, d1, rs1, fe, ec, dn);
        check("cmd03_done", 32'(dn), 32'd28);

        send(1'b1, 8'h01, d1, rs1, fe, ec, dn);
        check("dat01_done", 32'(dn), 32'd13);

        // Overflow: second write 4 cycles after the first is dropped.
        rs_i   = 1'b1;
        data_i = 8'h41;
        wr_i   = 1'b1;
        tick();
        wr_i = 1'b0;
        check("ovf_full", 32'(full_o), 32'h1);
        tick();
        tick();
        tick();
        data_i = 8'h42;
        wr_i   = 1'b1;
        tick();
        wr_i = 1'b0;
        check("ovf_flag", 32'(ovf_o),    32'h1);
        check("ovf_data", 32'(lcd_data), 32'h41);
        lowc = -1;
        for (int c = 0; c < 100 && lowc < 0; c++) begin
            tick();
            if (!busy_o) lowc = c;
        end
        check("ovf_drain", 32'(lowc >= 0), 32'h1);
        check("ovf_keep",  32'(lcd_data),  32'h41);
        check("ovf_stick", 32'(ovf_o),     32'h1);

        // Reset in the middle of the enable pulse.
        rs_i   = 1'b1;
        data_i = 8'h60;
        wr_i   = 1'b1;
        tick();
        wr_i = 1'b0;
        tick();
        tick();
        check("mid_en_hi", 32'(lcd_en), 32'h1);
        rst = 1'b0;
        tick();
        check("mid_en",   32'(lcd_en),   32'h0);
        check("mid_data", 32'(lcd_data), 32'h00);
        check("mid_busy", 32'(busy_o),   32'h0);
        check("mid_ovf",  32'(ovf_o),    32'h0);
        rst = 1'b1;
        tick();
        send(1'b1, 8'h41, d1, rs1, fe, ec, dn);
        check("post_latch", 32'(d1), 32'h41);
        check("post_en_at", 32'(fe), 32'd3);
        check("post_done",  32'(dn), 32'd13);

        // Back-to-back: second write lands on the EXEC-end cycle (cycle 12).
        rs_i   = 1'b1;
        data_i = 8'h50;
        wr_i   = 1'b1;
        lowc   = -1;
        ec     = 0;
        en2    = -1;
        d1     = 8'hxx;
        for (int c = 1; c <= 100 && lowc < 0; c++) begin
            tick();
            wr_i = 1'b0;
            if (c == 12) begin
                data_i = 8'h51;
                wr_i   = 1'b1;
            end
            if (c == 13) d1 = lcd_data;
            if (lcd_en) begin
                ec++;
                if (c >= 13 && en2 < 0) en2 = c;
            end
            if (!busy_o) lowc = c;
        end
        check("b2b_data",  32'(d1),    32'h51);
        check("b2b_en2",   32'(en2),   32'd15);
        check("b2b_en_n",  32'(ec),    32'd6);
        check("b2b_done",  32'(lowc),  32'd25);
        check("b2b_ovf",   32'(ovf_o), 32'h0);

        tick();
        rw_mon = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
